tile_map_arbiter: RTL and testbench

- Shares one single-port, synchronous-read tile-map RAM between two requesters.
- Requester 1 is the display path: graphics pixel fetch, absolute priority, fixed one-cycle latency.
- Requester 2 is the robot game logic: reads and writes through a req/gnt handshake. Its writes are posted into a small FIFO and drained whenever the display leaves the RAM idle (blanking or gaps).
- Sits between the graphics block, the robot/pipe logic and the map RAM, in the 50 MHz domain.

---
 rtl/tile_map_arbiter.sv | 152 +++++++++++++++
 tb/tb_tile_map_arbiter.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tile_map_arbiter.sv
// Single-port tile-map RAM arbiter: display reads take absolute priority, logic
// writes are posted into a FIFO and drained in idle cycles, logic reads wait for an empty FIFO.
module tile_map_arbiter #(
    parameter int ADDR_W     = 11,
    parameter int DATA_W     = 4,
    parameter int WBUF_DEPTH = 4
) (
    input  logic                              clock_50,
    input  logic                              reset_key,
    input  logic                              disp_req,
    input  logic [ADDR_W-1:0]                 disp_addr,
    output logic [DATA_W-1:0]                 disp_data,
    output logic                              disp_valid,
    input  logic                              lg_req,
    input  logic                              lg_we,
    input  logic [ADDR_W-1:0]                 lg_addr,
    input  logic [DATA_W-1:0]                 lg_wdata,
    output logic                              lg_gnt,
    output logic [DATA_W-1:0]                 lg_rdata,
    output logic                              lg_rvalid,
    output logic [$clog2(WBUF_DEPTH):0]       wbuf_level,
    output logic [ADDR_W-1:0]                 ram_addr,
    output logic                              ram_we,
    output logic [DATA_W-1:0]                 ram_wdata,
    input  logic [DATA_W-1:0]                 ram_rdata
);

    localparam int PTR_W = $clog2(WBUF_DEPTH);
    localparam int LVL_W = PTR_W + 1;

    typedef enum logic [1:0] {
        OWN_IDLE,
        OWN_DISP,
        OWN_DRAIN,
        OWN_LREAD
    } owner_e;

    owner_e                  owner;
    logic [ADDR_W-1:0]       fifo_addr_q [WBUF_DEPTH];
    logic [DATA_W-1:0]       fifo_data_q [WBUF_DEPTH];
    logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]        level_q, level_d;
    logic [ADDR_W-1:0]       ram_addr_q;
    logic [DATA_W-1:0]       ram_wdata_q;
    logic                    disp_valid_q, disp_valid_d;
    logic                    lg_rvalid_q, lg_rvalid_d;
    logic [DATA_W-1:0]       disp_hold_q, disp_hold_d;
    logic [DATA_W-1:0]       lg_hold_q, lg_hold_d;
    logic                    fifo_empty;
    logic                    has_room;
    logic                    push;
    logic                    pop;

    assign fifo_empty = (level_q == '0);
    assign has_room   = (level_q < LVL_W'(WBUF_DEPTH));

    // Gating with reset_key keeps the RAM quiet while reset is asserted,
    // even though ownership is otherwise decided combinationally.
    always_comb begin
        owner = OWN_IDLE;
        if (reset_key) begin
            if (disp_req)
                owner = OWN_DISP;
            else if (!fifo_empty)
                owner = OWN_DRAIN;
            else if (lg_req && !lg_we)
                owner = OWN_LREAD;
        end
    end

    assign push   = reset_key & lg_req & lg_we & has_room;
    assign pop    = (owner == OWN_DRAIN);
    assign lg_gnt = push | (owner == OWN_LREAD);
    assign ram_we = pop;

    always_comb begin
        ram_addr  = ram_addr_q;
        ram_wdata = ram_wdata_q;
        case (owner)
            OWN_DISP:  ram_addr = disp_addr;
            OWN_DRAIN: begin
                ram_addr  = fifo_addr_q[rd_ptr_q];
                ram_wdata = fifo_data_q[rd_ptr_q];
            end
            OWN_LREAD: ram_addr = lg_addr;
            default:   ram_addr = ram_addr_q;
        endcase
    end

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        level_d  = level_q;
        case ({push, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    always_comb begin
        disp_valid_d = (owner == OWN_DISP);
        lg_rvalid_d  = (owner == OWN_LREAD);
        disp_hold_d  = disp_valid_q ? ram_rdata : disp_hold_q;
        lg_hold_d    = lg_rvalid_q  ? ram_rdata : lg_hold_q;
    end

    // Read data is passed straight through in the valid cycle and latched for later.
    assign disp_valid = disp_valid_q;
    assign disp_data  = disp_valid_q ? ram_rdata : disp_hold_q;
    assign lg_rvalid  = lg_rvalid_q;
    assign lg_rdata   = lg_rvalid_q ? ram_rdata : lg_hold_q;
    assign wbuf_level = level_q;

    always_ff @(posedge clock_50 or negedge reset_key) begin
        if (!reset_key) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            level_q      <= '0;
            ram_addr_q   <= '0;
            ram_wdata_q  <= '0;
            disp_valid_q <= 1'b0;
            lg_rvalid_q  <= 1'b0;
            disp_hold_q  <= '0;
            lg_hold_q    <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            level_q      <= level_d;
            ram_addr_q   <= ram_addr;
            ram_wdata_q  <= ram_wdata;
            disp_valid_q <= disp_valid_d;
            lg_rvalid_q  <= lg_rvalid_d;
            disp_hold_q  <= disp_hold_d;
            lg_hold_q    <= lg_hold_d;
        end
    end

    always_ff @(posedge clock_50 or negedge reset_key) begin
        if (!reset_key) begin
            for (int unsigned i = 0; i < WBUF_DEPTH; i++) begin
                fifo_addr_q[i] <= '0;
                fifo_data_q[i] <= '0;
            end
        end else if (push) begin
            fifo_addr_q[wr_ptr_q] <= lg_addr;
            fifo_data_q[wr_ptr_q] <= lg_wdata;
        end
    end

endmodule

// File: tb/tb_tile_map_arbiter.sv
// Directed bench for tile_map_arbiter with a behavioural synchronous-read RAM.
module tb_tile_map_arbiter;

    logic        clk;
    logic        reset_key;
    logic        disp_req;
    logic [10:0] disp_addr;
    logic [3:0]  disp_data;
    logic        disp_valid;
    logic        lg_req;
    logic        lg_we;
    logic [10:0] lg_addr;
    logic [3:0]  lg_wdata;
    logic        lg_gnt;
    logic [3:0]  lg_rdata;
    logic        lg_rvalid;
    logic [2:0]  wbuf_level;
    logic [10:0] ram_addr;
    logic        ram_we;
    logic [3:0]  ram_wdata;
    logic [3:0]  ram_rdata;

    logic [3:0]  mem [2048];
    logic        preload_done;

    int checks;
    int errors;

    tile_map_arbiter #(
        .ADDR_W    (11),
        .DATA_W    (4),
        .WBUF_DEPTH(4)
    ) dut (
        .clock_50  (clk),
        .reset_key (reset_key),
        .disp_req  (disp_req),
        .disp_addr (disp_addr),
        .disp_data (disp_data),
        .disp_valid(disp_valid),
        .lg_req    (lg_req),
        .lg_we     (lg_we),
        .lg_addr   (lg_addr),
        .lg_wdata  (lg_wdata),
        .lg_gnt    (lg_gnt),
        .lg_rdata  (lg_rdata),
        .lg_rvalid (lg_rvalid),
        .wbuf_level(wbuf_level),
        .ram_addr  (ram_addr),
        .ram_we    (ram_we),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial preload_done = 1'b0;

    // Read-first single-port RAM; contents are seeded on the first edge.
    always @(posedge clk) begin
        if (!preload_done) begin
            for (int i = 0; i < 2048; i++) mem[i] <= 4'h0;
            mem[11'h005] <= 4'h9;
            mem[11'h030] <= 4'h7;
            mem[11'h031] <= 4'h6;
            ram_rdata    <= 4'h0;
            preload_done <= 1'b1;
        end else begin
            if (ram_we) mem[ram_addr] <= ram_wdata;
            ram_rdata <= mem[ram_addr];
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        reset_key = 1'b0;
        disp_req  = 1'b0;
        disp_addr = 11'h000;
        lg_req    = 1'b1;
        lg_we     = 1'b1;
        lg_addr   = 11'h3ff;
        lg_wdata  = 4'hf;

        // Reset held with a pending write request
        tick(); tick(); settle();
        chk("rst_level", 16'(wbuf_level), 16'd0);
        chk("rst_ram_we", 16'(ram_we), 16'd0);
        chk("rst_disp_valid", 16'(disp_valid), 16'd0);
        chk("rst_lg_rvalid", 16'(lg_rvalid), 16'd0);
        chk("rst_ram_addr", 16'(ram_addr), 16'h000);
        chk("rst_ram_wdata", 16'(ram_wdata), 16'h0);
        chk("rst_disp_data", 16'(disp_data), 16'h0);
        chk("rst_lg_rdata", 16'(lg_rdata), 16'h0);
        reset_key = 1'b1;
        lg_req    = 1'b0;
        tick(); settle();
        chk("post_level", 16'(wbuf_level), 16'd0);
        chk("post_ram_we", 16'(ram_we), 16'd0);
        chk("post_disp_valid", 16'(disp_valid), 16'd0);
        chk("post_lg_rvalid", 16'(lg_rvalid), 16'd0);

        // Display latency
        disp_req  = 1'b1;
        disp_addr = 11'h005;
        settle();
        chk("disp_ram_addr", 16'(ram_addr), 16'h005);
        chk("disp_ram_we", 16'(ram_we), 16'd0);
        chk("disp_valid_early", 16'(disp_valid), 16'd0);
        tick();
        disp_req = 1'b0;
        settle();
        chk("disp_valid", 16'(disp_valid), 16'd1);
        chk("disp_data", 16'(disp_data), 16'h9);
        tick(); settle();
        chk("disp_valid_clr", 16'(disp_valid), 16'd0);
        chk("disp_data_hold", 16'(disp_data), 16'h9);

        // Posted writes while display owns the RAM
        disp_req  = 1'b1;
        disp_addr = 11'h100;
        for (int i = 0; i < 3; i++) begin
            lg_req   = 1'b1;
            lg_we    = 1'b1;
            lg_addr  = 11'h010 + 11'(i);
            lg_wdata = 4'(i + 1);
            settle();
            chk("pw_gnt", 16'(lg_gnt), 16'd1);
            chk("pw_we_blocked", 16'(ram_we), 16'd0);
            tick();
        end
        lg_req = 1'b0;
        settle();
        chk("pw_level3", 16'(wbuf_level), 16'd3);
        chk("pw_we_idle", 16'(ram_we), 16'd0);
        tick(); settle();
        chk("pw_level3_hold", 16'(wbuf_level), 16'd3);
        disp_req = 1'b0;
        settle();
        for (int i = 0; i < 3; i++) begin
            chk("pw_drain_we", 16'(ram_we), 16'd1);
            chk("pw_drain_addr", 16'(ram_addr), 16'h010 + 16'(i));
            chk("pw_drain_wdata", 16'(ram_wdata), 16'(i + 1));
            chk("pw_drain_level", 16'(wbuf_level), 16'(3 - i));
            tick(); settle();
        end
        chk("pw_done_we", 16'(ram_we), 16'd0);
        chk("pw_done_level", 16'(wbuf_level), 16'd0);
        chk("pw_addr_hold", 16'(ram_addr), 16'h012);

        // FIFO full
        disp_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            lg_req   = 1'b1;
            lg_we    = 1'b1;
            lg_addr  = 11'h040 + 11'(i);
            lg_wdata = 4'(i + 4);
            settle();
            chk("full_fill_gnt", 16'(lg_gnt), 16'd1);
            tick();
        end
        lg_addr  = 11'h044;
        lg_wdata = 4'h8;
        settle();
        chk("full_gnt0", 16'(lg_gnt), 16'd0);
        chk("full_level4", 16'(wbuf_level), 16'd4);
        tick(); settle();
        chk("full_gnt0_wait", 16'(lg_gnt), 16'd0);
        disp_req = 1'b0;
        settle();
        chk("full_gnt0_pop", 16'(lg_gnt), 16'd0);
        chk("full_pop_we", 16'(ram_we), 16'd1);
        chk("full_pop_addr", 16'(ram_addr), 16'h040);
        tick(); settle();
        chk("full_gnt1", 16'(lg_gnt), 16'd1);
        chk("full_level3", 16'(wbuf_level), 16'd3);
        chk("full_addr41", 16'(ram_addr), 16'h041);
        chk("full_wdata5", 16'(ram_wdata), 16'h5);
        tick();
        lg_req = 1'b0;
        settle();
        chk("full_pushpop_level", 16'(wbuf_level), 16'd3);
        chk("full_addr42", 16'(ram_addr), 16'h042);
        chk("full_wdata6", 16'(ram_wdata), 16'h6);
        tick(); settle();
        chk("full_level2", 16'(wbuf_level), 16'd2);
        chk("full_addr43", 16'(ram_addr), 16'h043);
        tick(); settle();
        chk("full_level1", 16'(wbuf_level), 16'd1);
        chk("full_addr44", 16'(ram_addr), 16'h044);
        chk("full_wdata8", 16'(ram_wdata), 16'h8);
        tick(); settle();
        chk("full_level0", 16'(wbuf_level), 16'd0);
        chk("full_we0", 16'(ram_we), 16'd0);

        // Read after write
        lg_req   = 1'b1;
        lg_we    = 1'b1;
        lg_addr  = 11'h020;
        lg_wdata = 4'ha;
        settle();
        chk("raw_wr_gnt", 16'(lg_gnt), 16'd1);
        chk("raw_wr_not_same_cycle", 16'(ram_we), 16'd0);
        tick();
        lg_we = 1'b0;
        settle();
        chk("raw_rd_blocked", 16'(lg_gnt), 16'd0);
        chk("raw_level1", 16'(wbuf_level), 16'd1);
        chk("raw_drain_we", 16'(ram_we), 16'd1);
        chk("raw_drain_addr", 16'(ram_addr), 16'h020);
        chk("raw_drain_wdata", 16'(ram_wdata), 16'ha);
        tick(); settle();
        chk("raw_rd_gnt", 16'(lg_gnt), 16'd1);
        chk("raw_rd_addr", 16'(ram_addr), 16'h020);
        chk("raw_rd_we", 16'(ram_we), 16'd0);
        chk("raw_rvalid_early", 16'(lg_rvalid), 16'd0);
        tick();
        lg_req = 1'b0;
        settle();
        chk("raw_rvalid", 16'(lg_rvalid), 16'd1);
        chk("raw_rdata", 16'(lg_rdata), 16'ha);
        tick(); settle();
        chk("raw_rvalid_clr", 16'(lg_rvalid), 16'd0);
        chk("raw_rdata_hold", 16'(lg_rdata), 16'ha);

        // Reset with two buffered writes
        disp_req  = 1'b1;
        disp_addr = 11'h100;
        for (int i = 0; i < 2; i++) begin
            lg_req   = 1'b1;
            lg_we    = 1'b1;
            lg_addr  = 11'h030 + 11'(i);
            lg_wdata = 4'(i + 1);
            settle();
            chk("mid_wr_gnt", 16'(lg_gnt), 16'd1);
            tick();
        end
        lg_req = 1'b0;
        settle();
        chk("mid_level2", 16'(wbuf_level), 16'd2);
        reset_key = 1'b0;
        settle();
        chk("mid_rst_level", 16'(wbuf_level), 16'd0);
        chk("mid_rst_we", 16'(ram_we), 16'd0);
        tick();
        reset_key = 1'b1;
        disp_req  = 1'b0;
        tick(); settle();
        chk("mid_after_we", 16'(ram_we), 16'd0);
        chk("mid_after_level", 16'(wbuf_level), 16'd0);
        disp_req  = 1'b1;
        disp_addr = 11'h030;
        tick();
        disp_req = 1'b0;
        settle();
        chk("mid_mem30", 16'(disp_data), 16'h7);
        disp_req  = 1'b1;
        disp_addr = 11'h031;
        tick();
        disp_req = 1'b0;
        settle();
        chk("mid_mem31", 16'(disp_data), 16'h6);

        // Reset with a read granted
        tick();
        lg_req  = 1'b1;
        lg_we   = 1'b0;
        lg_addr = 11'h005;
        settle();
        chk("mid_rd_gnt", 16'(lg_gnt), 16'd1);
        reset_key = 1'b0;
        lg_req    = 1'b0;
        settle();
        chk("mid_rd_rvalid0", 16'(lg_rvalid), 16'd0);
        tick(); settle();
        chk("mid_rd_rvalid1", 16'(lg_rvalid), 16'd0);
        reset_key = 1'b1;
        tick(); settle();
        chk("mid_rd_rvalid2", 16'(lg_rvalid), 16'd0);
        chk("mid_rd_rdata", 16'(lg_rdata), 16'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
